// File: rtl/pwconv_pkg.sv
// Shared constants and types for the pointwise-conv requantize/pack block.
// Build option: define PWCONV_RELU_EN to clamp negative results to zero.
package pwconv_pkg;

    localparam int CH      = 32;
    localparam int LANES   = 4;
    localparam int ACC_W   = 32;
    localparam int SCALE_W = 16;
    localparam int SHIFT_W = 6;
    localparam int Q_W     = 8;
    localparam int CNT_W   = 5;
    localparam int POS_W   = 4;
    localparam int PROD_W  = ACC_W + SCALE_W + 1;

    localparam logic signed [Q_W-1:0] Q_MAX = 8'sh7F;
`ifdef PWCONV_RELU_EN
    localparam logic signed [Q_W-1:0] Q_MIN = 8'sh00;
`else
    localparam logic signed [Q_W-1:0] Q_MIN = 8'sh80;
`endif

    typedef logic [0:CH*Q_W-1] pword_t;

    typedef struct packed {
        logic              valid;
        logic [CNT_W-1:0]  cnt;
        logic [POS_W-1:0]  pos;
    } beat_tag_t;

    // Saturate a rounded, shifted product into the int8 output range.
    function automatic logic [Q_W-1:0] clamp_q(input logic signed [PROD_W:0] v);
        logic [Q_W-1:0] res;
        if (v > PROD_W'(Q_MAX)) begin
            res = Q_MAX;
        end else if (v < PROD_W'(Q_MIN)) begin
            res = Q_MIN;
        end else begin
            res = v[Q_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/pwconv_requant_lane.sv
// One requantization lane: S1 scale multiply, S2 round/shift/clamp to int8.
// Both stages hold their contents whenever en is low.
module pwconv_requant_lane
    import pwconv_pkg::*;
(
    input  logic               clk,
    input  logic               rst_b,
    input  logic               en,
    input  logic [ACC_W-1:0]   data,
    input  logic [SCALE_W-1:0] scale,
    input  logic [SHIFT_W-1:0] shift,
    output logic [Q_W-1:0]     q
);

    logic signed [PROD_W-1:0] prod_r;
    logic signed [PROD_W:0]   rnd_s;
    logic signed [PROD_W:0]   sum_s;
    logic signed [PROD_W:0]   shr_s;

    // S1: signed accumulator times zero-extended unsigned scale.
    always_ff @(posedge clk) begin
        if (rst_b) begin
            prod_r <= '0;
        end else if (en) begin
            prod_r <= $signed(data) * $signed({1'b0, scale});
        end else begin
            prod_r <= prod_r;
        end
    end

    // Round half up before the arithmetic shift; one extra bit keeps the add from overflowing.
    always_comb begin
        rnd_s = '0;
        if (shift != 6'd0) begin
            rnd_s = $signed({{PROD_W{1'b0}}, 1'b1} << (shift - 6'd1));
        end else begin
            rnd_s = '0;
        end
        sum_s = $signed({prod_r[PROD_W-1], prod_r}) + rnd_s;
        shr_s = sum_s >>> shift;
    end

    // S2: register the clamped int8 result.
    always_ff @(posedge clk) begin
        if (rst_b) begin
            q <= '0;
        end else if (en) begin
            q <= clamp_q(shr_s);
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/pwconv_requant_pack.sv
// Requantizes four accumulator lanes per beat and packs 32 channels per pixel into 256-bit words.
// Build option: PWCONV_RELU_EN (see pwconv_pkg) selects a zero lower clamp.
module pwconv_requant_pack
    import pwconv_pkg::*;
(
    input  logic               clk,
    input  logic               rst_b,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [4:0]         cnt_in,
    input  logic [3:0]         pos_in,
    input  logic [31:0]        data_in0,
    input  logic [31:0]        data_in1,
    input  logic [31:0]        data_in2,
    input  logic [31:0]        data_in3,
    input  logic [15:0]        quant_scale,
    input  logic [5:0]         quant_shift,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [3:0]         pos_out,
    output logic [0:255]       data_out0,
    output logic [0:255]       data_out1,
    output logic [0:255]       data_out2,
    output logic [0:255]       data_out3,
    output logic               err
);

    logic                adv_s;
    logic                load_s;
    logic                seq_bad_s;
    logic [ACC_W-1:0]    din_s       [LANES];
    logic [Q_W-1:0]      q_s         [LANES];
    pword_t              next_word_s [LANES];
    pword_t              buf_r       [LANES];
    beat_tag_t           s1_r;
    beat_tag_t           s2_r;
    logic [CNT_W-1:0]    prev_cnt_r;
    logic [POS_W-1:0]    grp_pos_r;

    assign din_s[0] = data_in0;
    assign din_s[1] = data_in1;
    assign din_s[2] = data_in2;
    assign din_s[3] = data_in3;

    // The whole pipeline freezes only while an unaccepted word sits in the output register.
    assign adv_s    = !(out_valid && !out_ready);
    assign in_ready = adv_s;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        pwconv_requant_lane u_lane (
            .clk   (clk),
            .rst_b (rst_b),
            .en    (adv_s),
            .data  (din_s[l]),
            .scale (quant_scale),
            .shift (quant_shift),
            .q     (q_s[l])
        );
    end

    // Buffer image with the current S2 byte merged in, so channel 31 lands in the emitted word.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            next_word_s[l] = buf_r[l];
            next_word_s[l][{s2_r.cnt, 3'b000} +: Q_W] = q_s[l];
        end
        load_s    = adv_s && s2_r.valid && (s2_r.cnt == 5'd31);
        seq_bad_s = (s2_r.cnt != 5'd0) &&
                    ((s2_r.cnt != (prev_cnt_r + 5'd1)) || (s2_r.pos != grp_pos_r));
    end

    // Beat tags, pack buffers and the sticky sequence checker.
    always_ff @(posedge clk) begin
        if (rst_b) begin
            s1_r       <= '0;
            s2_r       <= '0;
            prev_cnt_r <= 5'd31;
            grp_pos_r  <= 4'd0;
            err        <= 1'b0;
            for (int l = 0; l < LANES; l++) begin
                buf_r[l] <= '0;
            end
        end else if (adv_s) begin
            s1_r <= '{valid: in_valid, cnt: cnt_in, pos: pos_in};
            s2_r <= s1_r;
            if (s2_r.valid) begin
                for (int l = 0; l < LANES; l++) begin
                    buf_r[l] <= next_word_s[l];
                end
                prev_cnt_r <= s2_r.cnt;
                if (s2_r.cnt == 5'd0) begin
                    grp_pos_r <= s2_r.pos;
                end else begin
                    grp_pos_r <= grp_pos_r;
                end
                err <= err | seq_bad_s;
            end else begin
                prev_cnt_r <= prev_cnt_r;
                grp_pos_r  <= grp_pos_r;
                err        <= err;
            end
        end else begin
            s1_r <= s1_r;
            s2_r <= s2_r;
        end
    end

    // Output word register: a new load wins over a same-cycle accept.
    always_ff @(posedge clk) begin
        if (rst_b) begin
            out_valid <= 1'b0;
            pos_out   <= 4'd0;
            data_out0 <= '0;
            data_out1 <= '0;
            data_out2 <= '0;
            data_out3 <= '0;
        end else if (load_s) begin
            out_valid <= 1'b1;
            pos_out   <= s2_r.pos;
            data_out0 <= next_word_s[0];
            data_out1 <= next_word_s[1];
            data_out2 <= next_word_s[2];
            data_out3 <= next_word_s[3];
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= out_valid;
        end
    end

endmodule

// File: tb/tb_pwconv_requant_pack.sv
// Directed bench for pwconv_requant_pack with a word scoreboard; honours PWCONV_RELU_EN.
module tb_pwconv_requant_pack;

`ifdef PWCONV_RELU_EN
    localparam longint LO       = 0;
    localparam logic [7:0] E_NEG1 = 8'h00;
    localparam logic [7:0] E_MIN  = 8'h00;
    localparam logic [7:0] E_R2L1 = 8'h00;
`else
    localparam longint LO       = -128;
    localparam logic [7:0] E_NEG1 = 8'hFF;
    localparam logic [7:0] E_MIN  = 8'h80;
    localparam logic [7:0] E_R2L1 = 8'hED;
`endif

    logic         clk = 1'b0;
    logic         rst_b = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [4:0]   cnt_in = 5'd0;
    logic [3:0]   pos_in = 4'd0;
    logic [31:0]  data_in0 = 32'd0, data_in1 = 32'd0, data_in2 = 32'd0, data_in3 = 32'd0;
    logic [15:0]  quant_scale = 16'd1;
    logic [5:0]   quant_shift = 6'd0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [3:0]   pos_out;
    logic [0:255] data_out0, data_out1, data_out2, data_out3;
    logic         err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]   pos;
        logic [0:255] w0, w1, w2, w3;
    } exp_t;
    exp_t sbq[$];
    logic [0:255] exp_w [4];

    pwconv_requant_pack dut (
        .clk(clk), .rst_b(rst_b), .in_valid(in_valid), .in_ready(in_ready),
        .cnt_in(cnt_in), .pos_in(pos_in),
        .data_in0(data_in0), .data_in1(data_in1), .data_in2(data_in2), .data_in3(data_in3),
        .quant_scale(quant_scale), .quant_shift(quant_shift),
        .out_valid(out_valid), .out_ready(out_ready), .pos_out(pos_out),
        .data_out0(data_out0), .data_out1(data_out1), .data_out2(data_out2), .data_out3(data_out3),
        .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] rq(input int d, input int unsigned s, input int sh);
        longint p;
        longint r;
        p = longint'(d) * longint'(s);
        if (sh > 0) r = (p + (longint'(1) <<< (sh - 1))) >>> sh;
        else        r = p;
        if (r > 127) r = 127;
        if (r < LO)  r = LO;
        return r[7:0];
    endfunction

    function automatic int gen(input int g, input int l, input int c);
        int v;
        case (g)
            1: v = (l == 0) ? c : (l == 1) ? -c : (l == 2) ? c * 10 : c * 3 - 40;
            2: v = (l == 0) ? 300 : (l == 1) ? c * 7 - 100 : (l == 2) ? -1000000 : int'($urandom);
            3: v = (l == 0) ? 8 : (l == 1) ? -24 : (l == 2) ? c - 16 : 24 + c;
            4: v = (l == 0) ? 1000 : (l == 1) ? -1000 : (l == 2) ? c * 1000 - 16000 : int'($urandom);
            default: v = c * 5 - 77 + l * 13;
        endcase
        return v;
    endfunction

    task automatic send_beat(input logic [4:0] c, input logic [3:0] p, input int g);
        int d [4];
        int n;
        logic ok;
        for (int l = 0; l < 4; l++) d[l] = gen(g, l, int'(c));
        cnt_in = c; pos_in = p; in_valid = 1'b1;
        data_in0 = d[0]; data_in1 = d[1]; data_in2 = d[2]; data_in3 = d[3];
        n = 0; ok = 1'b0;
        while (!ok && n < 200) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            else n++;
        end
        chk("beat_accept", ok, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int l = 0; l < 4; l++)
            exp_w[l][{c, 3'b000} +: 8] = rq(d[l], int'(quant_scale), int'(quant_shift));
        if (c == 5'd31) sbq.push_back('{p, exp_w[0], exp_w[1], exp_w[2], exp_w[3]});
    endtask

    task automatic send_range(input int g, input logic [3:0] p, input int lo, input int hi);
        for (int c = lo; c <= hi; c++) send_beat(5'(c), p, g);
    endtask

    task automatic do_reset();
        rst_b = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_b = 1'b0;
    endtask

    task automatic set_q(input logic [15:0] s, input logic [5:0] sh);
        repeat (3) @(posedge clk);
        #1;
        quant_scale = s;
        quant_shift = sh;
    endtask

    task automatic wait_ov(input string tag);
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk(tag, out_valid, 1'b1);
    endtask

    // Scoreboard: compare every word at the cycle the consumer takes it.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_b && out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                chk("sb_unexpected_word", out_valid, 1'b0);
            end else begin
                e = sbq.pop_front();
                chk("sb_pos", pos_out, e.pos);
                chk("sb_word0", data_out0, e.w0);
                chk("sb_word1", data_out1, e.w1);
                chk("sb_word2", data_out2, e.w2);
                chk("sb_word3", data_out3, e.w3);
            end
        end
    end

    initial begin
        int n;
        for (int l = 0; l < 4; l++) exp_w[l] = '0;
        do_reset();
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_err", err, 1'b0);
        chk("rst_pos_out", pos_out, 4'd0);
        chk("rst_data_out0", data_out0, 256'd0);

        // Reset in the middle of a group, then a full group must pack cleanly.
        send_range(9, 4'd3, 0, 9);
        do_reset();
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_err", err, 1'b0);
        chk("midrst_in_ready", in_ready, 1'b1);

        // Basic pass-through with latency check on the last beat.
        send_range(1, 4'd5, 0, 31);
        chk("lat_t1", out_valid, 1'b0);
        @(posedge clk); #1;
        chk("lat_t2", out_valid, 1'b0);
        @(posedge clk); #1;
        chk("lat_t3", out_valid, 1'b1);
        chk("basic_pos", pos_out, 4'd5);
        chk("basic_byte31", data_out0[248:255], 8'd31);

        // Rounding with scale 3, shift 4.
        set_q(16'd3, 6'd4);
        out_ready = 1'b0;
        send_range(2, 4'd6, 0, 31);
        wait_ov("rnd1_valid");
        chk("rnd1_300x3", data_out0[0:7], 8'd56);
        chk("rnd1_neg300", data_out1[0:7], E_R2L1);
        chk("rnd1_sat_lo", data_out2[0:7], E_MIN);
        chk("rnd1_pos", pos_out, 4'd6);
        out_ready = 1'b1;

        // Half-way rounding with scale 1, shift 4.
        set_q(16'd1, 6'd4);
        out_ready = 1'b0;
        send_range(3, 4'd2, 0, 31);
        wait_ov("rnd2_valid");
        chk("rnd2_half_up", data_out0[0:7], 8'd1);
        chk("rnd2_neg1p5", data_out1[0:7], E_NEG1);
        out_ready = 1'b1;

        // Saturation with scale 1, shift 0.
        set_q(16'd1, 6'd0);
        out_ready = 1'b0;
        send_range(4, 4'd11, 0, 31);
        wait_ov("sat_valid");
        chk("sat_hi", data_out0[120:127], 8'd127);
        chk("sat_lo", data_out1[120:127], E_MIN);
        out_ready = 1'b1;

        // Backpressure: first word held while the next group is streaming.
        set_q(16'd2, 6'd1);
        out_ready = 1'b0;
        send_range(5, 4'd7, 0, 31);
        send_beat(5'd0, 4'd8, 6);
        send_beat(5'd1, 4'd8, 6);
        chk("bp_in_ready_low", in_ready, 1'b0);
        chk("bp_out_valid", out_valid, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        chk("bp_hold_valid", out_valid, 1'b1);
        chk("bp_hold_pos", pos_out, 4'd7);
        out_ready = 1'b1;
        send_range(6, 4'd8, 2, 31);

        n = 0;
        while (sbq.size() != 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("sb_drained", sbq.size(), 0);
        chk("no_err_clean", err, 1'b0);

        // Sequence errors: skipped channel, then a position change mid-group.
        do_reset();
        send_beat(5'd0, 4'd9, 7);
        send_beat(5'd1, 4'd9, 7);
        send_beat(5'd3, 4'd9, 7);
        repeat (3) @(posedge clk);
        #1;
        chk("seq_skip_err", err, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        chk("seq_err_sticky", err, 1'b1);
        do_reset();
        chk("seq_err_cleared", err, 1'b0);
        send_beat(5'd0, 4'd9, 7);
        send_beat(5'd1, 4'd9, 7);
        send_beat(5'd2, 4'd10, 7);
        repeat (3) @(posedge clk);
        #1;
        chk("seq_pos_err", err, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pwconv_requant_pack.md
# pwconv_requant_pack

Requantizes the four signed 32-bit pointwise-conv accumulator results produced each beat for one output channel. Each result is scaled, rounded, shifted and clamped to int8, with optional ReLU. The block packs all 32 output channels of four pixels into four 256-bit int8 feature words and emits them with their position tag. It sits directly downstream of the 1×1×32 pointwise-conv datapath and upstream of the feature-map write buffer.

## Interface
Parameters
- CH, 32, output channels per packed word (fixed by package)
- LANES, 4, pixels processed in parallel

Ports
- clk  in  1  clock
- rst_b  in  1  synchronous reset, active-high (1 = reset); sampled on rising clk
- in_valid  in  1  beat valid
- in_ready  out  1  block can accept a beat this cycle
- cnt_in  in  5  output-channel index of this beat
- pos_in  in  4  pixel-group position tag
- data_in0..3  in  32 each  signed accumulator, lanes 0..3
- quant_scale  in  16  unsigned multiplier; static while busy
- quant_shift  in  6  right-shift amount, 0..47; static while busy
- out_valid  out  1  packed word valid
- out_ready  in  1  consumer accepts packed word
- pos_out  out  4  position tag of packed word
- data_out0..3  out  [0:255] each  packed int8; channel c at bits [8c : 8c+7]
- err  out  1  sticky sequence error

## Operation
- Beat accepted when in_valid && in_ready.
- Global advance: adv = !(out_valid && !out_ready); in_ready = adv; all pipeline stages hold when adv=0.
- S1: prod = signed(data_inN) × {1'b0,quant_scale}, 49-bit signed, registered per lane.
- S2 rounding: if shift>0, r = (prod + (1<<(shift-1))) >>> shift (arithmetic); else r = prod.
- S2 clamp: hi 127; lo 0 (ReLU) or −128; result q int8; registered with cnt, pos and valid.
- S3 pack: q written into byte lane cnt of the pack buffer per lane.
  - cnt==0 latches pos and starts a group.
  - cnt==31 loads the output register with the full buffer (including this byte), sets out_valid and pos_out.
- out_valid clears on the cycle out_ready is high while out_valid is high, unless a new word loads in the same cycle.
- Sequence check at S3: err is set, and stays set until reset, when either holds:
  - cnt is not the previous cnt+1 (and not 0);
  - pos differs from the group's latched pos.
- An erroneous beat is still written.
- Reset values: in_ready 1, out_valid 0, pos_out 0, data_out* 0, err 0, pipeline valids 0, buffer 0.
- Reset mid-group discards partial group and in-flight beats; the next group must start at cnt 0.

## Timing
- Latency: beat with cnt==31 accepted at cycle t → out_valid high at cycle t+3.
- Throughput: one beat per cycle; one packed word per 32 beats.
- Stall: out_valid=1 and out_ready=0 freezes S1–S3 and drops in_ready in the same cycle (combinational from out_valid/out_ready).
- out_valid held with data stable until accepted.
- Simultaneous accept plus new load: the new word replaces the old word and out_valid stays 1.
- quant_scale and quant_shift are sampled in S1/S2 and must not change while any beat is in flight.

## Configuration
- PWCONV_RELU_EN defined: lower clamp 0; negative results output 0.
- PWCONV_RELU_EN undefined: lower clamp −128; signed int8 output.

## Structure
- Package pwconv_pkg holds:
  - CH=32, LANES=4, ACC_W=32, SCALE_W=16, SHIFT_W=6, Q_W=8;
  - the int8 clamp limits;
  - a typedef for the 256-bit packed word.
- Sub-module pwconv_requant_lane implements S1 multiply and S2 round/shift/clamp for one lane, takes the stage enable, and is instantiated LANES times.
- Pack buffer, output register, handshake and sequence checker live in the top.

## Test plan
- Reset: drive rst_b=1 for 2 cycles mid-group → out_valid 0, err 0, in_ready 1; then a full group cnt 0..31 packs normally.
- Basic: scale=1, shift=0, lane0 data=c for cnt=c, pos=5 → at t+3, data_out0 byte c = c, pos_out=5.
- Rounding: data=300, scale=3, shift=4 → 900/16=56.25 → 56; data=8, scale=1, shift=4 → 0.5 rounds to 1; data=−24, shift=4 → −1.5 rounds to −1 (RELU off) / 0 (RELU on).
- Saturation: data=1000, scale=1, shift=0 → 127; data=−1000 → −128 without PWCONV_RELU_EN, 0 with it.
- Backpressure: hold out_ready=0 after first word, stream second group → in_ready falls when out_valid rises, no beat lost, second word appears intact after out_ready=1.
- Sequence error: send cnt 0,1,3 → err=1 and stays 1; changing pos at cnt 2 also sets err.
